// File: rtl/joy_arb_pkg.sv
// Shared types and mode encodings for the user-port joystick arbiter.
package joy_arb_pkg;

    typedef enum logic [1:0] {
        SNIFF = 2'd0,
        DB15  = 2'd1,
        OFF   = 2'd2,
        MD    = 2'd3
    } arb_state_t;

    localparam logic [1:0] MODE_MD   = 2'b10;
    localparam logic [1:0] MODE_DB15 = 2'b01;

endpackage

// File: rtl/joy_sense_debounce.sv
// Synchronises an asynchronous active-low sense line and qualifies it once it
// has stayed low long enough to saturate a W-bit counter.
module joy_sense_debounce #(
    parameter int W = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic in_n,
    output logic qual
);

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

    logic         r_sync1;
    logic         r_sync2;
    logic [W-1:0] r_cnt;
    logic         r_qual;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_cnt   <= '0;
            r_qual  <= 1'b0;
        end else begin
            r_sync1 <= in_n;
            r_sync2 <= r_sync1;
            if (r_sync2) begin
                r_cnt  <= '0;
                r_qual <= 1'b0;
            end else if (r_cnt != CNT_MAX) begin
                // Flag rises together with the count reaching all-ones.
                r_cnt  <= r_cnt + ONE;
                r_qual <= (r_cnt == (CNT_MAX - ONE));
            end else begin
                r_qual <= 1'b1;
            end
        end
    end

    assign qual = r_qual;

endmodule

// File: rtl/joy_port_arb.sv
// User-port joystick arbiter: detects DB9 MD splitter / DB15 adapter / none,
// gates player words on activity and produces a hold-qualified OSD button.
module joy_port_arb
    import joy_arb_pkg::*;
#(
    parameter int DEBOUNCE_W = 16,
    parameter int OSD_HOLD_W = 24,
    parameter int ACT_BIT    = 2,
    parameter int OSD_A      = 10,
    parameter int OSD_B      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdsense_n,
    input  logic [2:0]  db15_sense_n,
    input  logic [15:0] joy_md1,
    input  logic [15:0] joy_md2,
    input  logic [15:0] joy_db15_1,
    input  logic [15:0] joy_db15_2,
    output logic [15:0] joy1,
    output logic [15:0] joy2,
    output logic [5:0]  joy_raw,
    output logic [1:0]  mode,
    output logic        osd_btn,
    output logic        p1_en,
    output logic        p2_en,
    output arb_state_t  dbg_state
);

    localparam logic [OSD_HOLD_W-1:0] OSD_MAX = '1;
    localparam logic [OSD_HOLD_W-1:0] OSD_ONE = {{(OSD_HOLD_W-1){1'b0}}, 1'b1};

    logic                  w_md_qual;
    logic                  w_off_qual;
    logic                  w_db15_act;
    logic [15:0]           w_sel1;
    logic [15:0]           w_sel2;
    logic                  w_gate;
    logic [15:0]           w_joy1_nxt;
    logic [15:0]           w_joy2_nxt;
    logic                  w_combo;
    logic [OSD_HOLD_W-1:0] w_osd_cnt_nxt;

    arb_state_t            r_state;
    logic [1:0]            r_mode;
    logic                  r_p1_en;
    logic                  r_p2_en;
    logic [15:0]           r_joy1;
    logic [15:0]           r_joy2;
    logic [5:0]            r_raw;
    logic [OSD_HOLD_W-1:0] r_osd_cnt;
    logic                  r_osd;

    joy_sense_debounce #(.W(DEBOUNCE_W)) u_md_sense (
        .clk   (clk),
        .reset (reset),
        .in_n  (mdsense_n),
        .qual  (w_md_qual)
    );

    // Any DB15 sense bit pulled low rules the DB15 adapter out.
    joy_sense_debounce #(.W(DEBOUNCE_W)) u_db15_sense (
        .clk   (clk),
        .reset (reset),
        .in_n  (&db15_sense_n),
        .qual  (w_off_qual)
    );

    assign w_db15_act = joy_db15_1[ACT_BIT] | joy_db15_2[ACT_BIT];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SNIFF;
            r_mode  <= MODE_DB15;
        end else begin
            r_mode <= (r_state == MD) ? MODE_MD : MODE_DB15;
            case (r_state)
                SNIFF: begin
                    if (w_md_qual)       r_state <= MD;
                    else if (w_off_qual) r_state <= OFF;
                    else if (w_db15_act) r_state <= DB15;
                end
                DB15: begin
                    if (w_md_qual)       r_state <= MD;
                    else if (w_off_qual) r_state <= OFF;
                end
                OFF: begin
                    if (w_md_qual)       r_state <= MD;
                end
                default: r_state <= MD;
            endcase
        end
    end

    always_comb begin
        w_sel1 = joy_db15_1;
        w_sel2 = joy_db15_2;
        case (r_state)
            MD: begin
                w_sel1 = joy_md1;
                w_sel2 = joy_md2;
            end
            OFF: begin
                w_sel1 = '0;
                w_sel2 = '0;
            end
            default: ;
        endcase
    end

    // Registered enables gate the outputs, so the first active word is dropped.
    assign w_gate     = r_p1_en | r_p2_en;
    assign w_joy1_nxt = w_gate ? w_sel1 : 16'h0000;
    assign w_joy2_nxt = w_gate ? w_sel2 : 16'h0000;

    assign w_combo       = r_joy1[OSD_A] & r_joy1[OSD_B];
    assign w_osd_cnt_nxt = !w_combo ? '0 :
                           (r_osd_cnt == OSD_MAX) ? r_osd_cnt : (r_osd_cnt + OSD_ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_p1_en   <= 1'b0;
            r_p2_en   <= 1'b0;
            r_joy1    <= '0;
            r_joy2    <= '0;
            r_raw     <= '0;
            r_osd_cnt <= '0;
            r_osd     <= 1'b0;
        end else begin
            r_p1_en <= r_p1_en | w_sel1[ACT_BIT];
            // A splitter mirrors P1 onto P2; only count P2 when P1 is idle.
            r_p2_en <= r_p2_en | (w_sel2[ACT_BIT] & ~w_sel1[ACT_BIT]);
            r_joy1    <= w_joy1_nxt;
            r_joy2    <= w_joy2_nxt;
            r_raw     <= w_joy1_nxt[5:0] | w_joy2_nxt[5:0];
            r_osd_cnt <= w_osd_cnt_nxt;
            r_osd     <= (w_osd_cnt_nxt == OSD_MAX);
        end
    end

    assign joy1      = r_joy1;
    assign joy2      = r_joy2;
    assign joy_raw   = r_raw;
    assign mode      = r_mode;
    assign osd_btn   = r_osd;
    assign p1_en     = r_p1_en;
    assign p2_en     = r_p2_en;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_joy_port_arb.sv
// Directed bench for joy_port_arb with small debounce/hold counters.
module tb_joy_port_arb;
    import joy_arb_pkg::*;

    logic        clk;
    logic        reset;
    logic        mdsense_n;
    logic [2:0]  db15_sense_n;
    logic [15:0] joy_md1;
    logic [15:0] joy_md2;
    logic [15:0] joy_db15_1;
    logic [15:0] joy_db15_2;
    logic [15:0] joy1;
    logic [15:0] joy2;
    logic [5:0]  joy_raw;
    logic [1:0]  mode;
    logic        osd_btn;
    logic        p1_en;
    logic        p2_en;
    arb_state_t  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    joy_port_arb #(
        .DEBOUNCE_W (4),
        .OSD_HOLD_W (3),
        .ACT_BIT    (2),
        .OSD_A      (10),
        .OSD_B      (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mdsense_n    (mdsense_n),
        .db15_sense_n (db15_sense_n),
        .joy_md1      (joy_md1),
        .joy_md2      (joy_md2),
        .joy_db15_1   (joy_db15_1),
        .joy_db15_2   (joy_db15_2),
        .joy1         (joy1),
        .joy2         (joy2),
        .joy_raw      (joy_raw),
        .mode         (mode),
        .osd_btn      (osd_btn),
        .p1_en        (p1_en),
        .p2_en        (p2_en),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_joy1"}, 32'(joy1), 32'h0);
        check_eq({tag, "_joy2"}, 32'(joy2), 32'h0);
        check_eq({tag, "_raw"},  32'(joy_raw), 32'h0);
        check_eq({tag, "_mode"}, 32'(mode), 32'h1);
        check_eq({tag, "_osd"},  32'(osd_btn), 32'h0);
        check_eq({tag, "_p1"},   32'(p1_en), 32'h0);
        check_eq({tag, "_p2"},   32'(p2_en), 32'h0);
        check_eq({tag, "_st"},   32'(dbg_state), 32'(SNIFF));
    endtask

    task automatic do_reset();
        mdsense_n    = 1'b1;
        db15_sense_n = 3'b111;
        joy_md1      = '0;
        joy_md2      = '0;
        joy_db15_1   = '0;
        joy_db15_2   = '0;
        reset        = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        int off_seen;
        reset = 1'b1;
        do_reset();
        check_reset_vals("rst");

        // DB15 activity: enable on the first word, output one cycle later
        joy_db15_1 = 16'h0004;
        tick(1);
        check_eq("db15_state", 32'(dbg_state), 32'(DB15));
        check_eq("db15_p1en", 32'(p1_en), 32'h1);
        check_eq("db15_first_gated", 32'(joy1), 32'h0);
        tick(1);
        check_eq("db15_joy1", 32'(joy1), 32'h0004);
        check_eq("db15_raw", 32'(joy_raw), 32'h04);
        check_eq("db15_mode", 32'(mode), 32'h1);
        check_eq("db15_p2en", 32'(p2_en), 32'h0);

        // Short MD sense pulse must not qualify
        mdsense_n = 1'b0;
        tick(10);
        mdsense_n = 1'b1;
        tick(20);
        check_eq("pulse_state", 32'(dbg_state), 32'(DB15));
        check_eq("pulse_mode", 32'(mode), 32'h1);

        // Long MD sense qualifies
        mdsense_n = 1'b0;
        tick(14);
        check_eq("md_early_mode", 32'(mode), 32'h1);
        tick(6);
        check_eq("md_state", 32'(dbg_state), 32'(MD));
        check_eq("md_mode", 32'(mode), 32'h2);
        joy_md1 = 16'h0123;
        tick(1);
        check_eq("md_joy1", 32'(joy1), 32'h0123);
        check_eq("md_raw", 32'(joy_raw), 32'h23);

        // OSD combo hold
        joy_md1 = 16'h0440;
        tick(1);
        check_eq("osd_joy1", 32'(joy1), 32'h0440);
        tick(6);
        check_eq("osd_not_yet", 32'(osd_btn), 32'h0);
        tick(1);
        check_eq("osd_on", 32'(osd_btn), 32'h1);
        joy_md1 = 16'h0000;
        tick(1);
        check_eq("osd_rel_joy1", 32'(joy1), 32'h0);
        check_eq("osd_still_on", 32'(osd_btn), 32'h1);
        joy_md1 = 16'h0440;
        tick(1);
        check_eq("osd_off", 32'(osd_btn), 32'h0);
        tick(4);
        check_eq("osd_restart", 32'(osd_btn), 32'h0);
        tick(3);
        check_eq("osd_on_again", 32'(osd_btn), 32'h1);

        // Reset mid-operation with osd_btn high
        reset     = 1'b1;
        mdsense_n = 1'b1;
        joy_md1   = '0;
        tick(1);
        check_reset_vals("midrst");
        reset = 1'b0;
        tick(1);

        // Simultaneous MD and DB15-off qualification: MD wins
        off_seen     = 0;
        db15_sense_n = 3'b110;
        mdsense_n    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (dbg_state == OFF) off_seen++;
        end
        check_eq("simul_never_off", 32'(off_seen), 32'h0);
        check_eq("simul_state", 32'(dbg_state), 32'(MD));
        check_eq("simul_mode", 32'(mode), 32'h2);

        // Splitter duplication guard
        joy_md1 = 16'h0004;
        joy_md2 = 16'h0004;
        tick(1);
        check_eq("dup_p1en", 32'(p1_en), 32'h1);
        check_eq("dup_p2en", 32'(p2_en), 32'h0);
        tick(1);
        check_eq("dup_joy2", 32'(joy2), 32'h0004);
        joy_md1 = 16'h0000;
        tick(1);
        check_eq("p2_p2en", 32'(p2_en), 32'h1);
        tick(1);
        check_eq("p2_joy1", 32'(joy1), 32'h0);
        check_eq("p2_joy2", 32'(joy2), 32'h0004);
        check_eq("p2_raw", 32'(joy_raw), 32'h04);

        // OFF path: DB15 ruled out, then MD splitter arrives
        do_reset();
        db15_sense_n = 3'b011;
        tick(20);
        check_eq("off_state", 32'(dbg_state), 32'(OFF));
        check_eq("off_mode", 32'(mode), 32'h1);
        joy_db15_1 = 16'h0004;
        tick(2);
        check_eq("off_p1en", 32'(p1_en), 32'h0);
        check_eq("off_joy1", 32'(joy1), 32'h0);
        mdsense_n = 1'b0;
        tick(20);
        check_eq("off_to_md", 32'(dbg_state), 32'(MD));
        check_eq("off_to_md_mode", 32'(mode), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
